dpcm_rle_encoder: RTL and testbench
===================================

// Module: dpcm_rle_encoder
// PURPOSE
//  Run-length encoder placed directly downstream of the DPCM difference stage.
//  - Consumes the stream of difference words. Flat signal regions make long runs of equal values.
//  - Each run is emitted as a two-word pair: {value, count}.
//  - Valid/ready handshake on both sides. Runs close on a value change, on MAX_RUN, or on Flush.
// PARAMETERS
//  WIDTH    8    data word width, in and out; the count word uses the same width
//  MAX_RUN  255  longest run per pair; legal range 1 .. 2**WIDTH-1
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  rst       in   1      asynchronous, active-high reset
//  ValidIn   in   1      upstream word valid
//  ReadyIn   out  1      block accepts DataIn this cycle
//  DataIn    in   WIDTH  difference word from the upstream stage
//  Flush     in   1      close the open run and emit it (end of frame)
//  ValidOut  out  1      DataOut holds a valid output word
//  ReadyOut  in   1      downstream accepts DataOut
//  DataOut   out  WIDTH  run value word, then run count word
// BEHAVIOUR
//  Transfers and outputs
//  - Input transfer: ValidIn && ReadyIn on a rising edge.
//  - Output transfer: ValidOut && ReadyOut on a rising edge.
//  - All outputs are registered.
//  - On rst assertion, immediately: ReadyIn=0, ValidOut=0, DataOut=0, state=IDLE, count=0, pending=0.
//  - First clock edge after rst deassertion: ReadyIn=1.
//  - An open run or pending word is discarded by reset. No partial pair is ever emitted.
//  FSM states: IDLE, RUN, EMIT_VAL, EMIT_CNT
//  - IDLE: ReadyIn=1.
//      - Accepted word -> run_val=DataIn, count=1, go to RUN.
//      - Flush in IDLE has no effect.
//  - RUN: ReadyIn = !Flush.
//      - Accepted DataIn==run_val -> count+1.
//          - If the new count==MAX_RUN: go to EMIT_VAL, pending=0.
//      - Accepted DataIn!=run_val -> next_val=DataIn, pending=1, go to EMIT_VAL.
//      - Flush=1 (no accept that cycle) -> go to EMIT_VAL, pending=0.
//  - EMIT_VAL: ValidOut=1, DataOut=run_val, ReadyIn=0.
//      - On output transfer -> go to EMIT_CNT.
//  - EMIT_CNT: ValidOut=1, DataOut=count, ReadyIn=0.
//      - On output transfer with pending=1 -> run_val=next_val, count=1, pending=0, go to RUN.
//      - On output transfer with pending=0 -> count=0, go to IDLE.
//  Timing
//  - An edge that closes a run makes ValidOut=1 with the value word in the next cycle.
//  - With ReadyOut held high the count word follows one cycle later.
//  - No bubble between the two words of a pair.
//  - Input stalls for exactly 2 cycles per emitted pair when ReadyOut=1.
//  - MAX_RUN=1: every accepted word is emitted as {v,1}.
//  Backpressure
//  - While ValidOut=1 && ReadyOut=0, DataOut and ValidOut hold stable.
//  - ValidOut never drops without a transfer.
//  Arithmetic
//  - count is WIDTH bits and never exceeds MAX_RUN, so it cannot wrap.
//  - Value compare is an exact WIDTH-bit equality.
//  Simultaneous events
//  - Flush together with ValidIn in RUN: the input is not accepted (ReadyIn=0). The run closes first.
//  - After a flush closes a run, the FSM returns to IDLE before taking new input.
//  - Flush in EMIT_* is ignored. A pending word restarts a run that a later Flush closes.
// TESTING
//  1. Basic run, ReadyOut=1
//     - Stimulus: DataIn 5,5,5,9, then Flush.
//     - Required: DataOut 5,3,9,1.
//  2. Saturation, MAX_RUN=255
//     - Stimulus: 300 words of 0x00, then Flush.
//     - Required: 0x00,0xFF,0x00,0x2D (45).
//  3. Backpressure
//     - Stimulus: ReadyOut=0 for 3 cycles during EMIT_VAL of value 7.
//     - Required: DataOut=7 and ValidOut=1 held all 3 cycles; ReadyIn=0; then 7,count delivered.
//  4. Alternating values
//     - Stimulus: 1,2,1, then Flush.
//     - Required: 1,1,2,1,1,1.
//     - Required: Flush in IDLE produces no output.
//  5. Flush with ValidIn in RUN
//     - Stimulus: Flush and ValidIn asserted in the same RUN cycle.
//     - Required: the word is not accepted; it is accepted later in IDLE and opens a new run.
//  6. Reset mid-operation
//     - Stimulus: async rst asserted while in EMIT_CNT.
//     - Required: ValidOut=0 without waiting for a clock edge; after release, input 4 then Flush -> 4,1 only.

Source files
------------

// File: rtl/dpcm_rle_encoder_if.sv
// Stream bundle for the DPCM run-length encoder: difference words in,
// {value, count} word pairs out, each side with its own valid/ready handshake.
interface dpcm_rle_encoder_if #(
  parameter int WIDTH = 8
);
  logic             ValidIn;
  logic             ReadyIn;
  logic [WIDTH-1:0] DataIn;
  logic             Flush;
  logic             ValidOut;
  logic             ReadyOut;
  logic [WIDTH-1:0] DataOut;

  // master: the stage that feeds words in and drains the pairs
  modport master (
    output ValidIn, DataIn, Flush, ReadyOut,
    input  ReadyIn, ValidOut, DataOut
  );

  modport slave (
    input  ValidIn, DataIn, Flush, ReadyOut,
    output ReadyIn, ValidOut, DataOut
  );
endinterface

// File: rtl/dpcm_rle_encoder.sv
// Run-length encoder behind the DPCM difference stage: each run of equal
// words leaves as a value word followed by a count word.
module dpcm_rle_encoder #(
  parameter int WIDTH   = 8,
  parameter int MAX_RUN = 255
) (
  input  logic         clk,
  input  logic         rst,
  dpcm_rle_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, EMIT_VAL, EMIT_CNT} state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_RUN);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, stateNxt;
  logic [WIDTH-1:0] runVal, runValNxt;
  logic [WIDTH-1:0] nextVal, nextValNxt;
  logic [WIDTH-1:0] count, countNxt;
  logic             pending, pendingNxt;
  logic             rdyQ, rdyNxt;
  logic             vldQ, vldNxt;
  logic [WIDTH-1:0] dataQ, dataNxt;
  logic [WIDTH-1:0] cntInc;
  logic             inAccept;
  logic             outXfer;

  // Flush must win over a word offered in the same RUN cycle, so it gates the
  // registered ready directly; that is the only combinational term on ReadyIn.
  assign bus.ReadyIn  = rdyQ && !(bus.Flush && (state == RUN));
  assign bus.ValidOut = vldQ;
  assign bus.DataOut  = dataQ;

  assign inAccept = bus.ValidIn && bus.ReadyIn;
  assign outXfer  = vldQ && bus.ReadyOut;
  assign cntInc   = count + ONE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      runVal  <= '0;
      nextVal <= '0;
      count   <= '0;
      pending <= 1'b0;
      rdyQ    <= 1'b0;
      vldQ    <= 1'b0;
      dataQ   <= '0;
    end else begin
      state   <= stateNxt;
      runVal  <= runValNxt;
      nextVal <= nextValNxt;
      count   <= countNxt;
      pending <= pendingNxt;
      rdyQ    <= rdyNxt;
      vldQ    <= vldNxt;
      dataQ   <= dataNxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    stateNxt   = state;
    runValNxt  = runVal;
    nextValNxt = nextVal;
    countNxt   = count;
    pendingNxt = pending;
    unique case (state)
      IDLE: begin
        if (inAccept) begin
          runValNxt  = bus.DataIn;
          countNxt   = ONE;
          pendingNxt = 1'b0;
          // a single word already fills the run when MAX_RUN is 1
          stateNxt   = (MAX_CNT == ONE) ? EMIT_VAL : RUN;
        end
      end
      RUN: begin
        if (bus.Flush) begin
          pendingNxt = 1'b0;
          stateNxt   = EMIT_VAL;
        end else if (inAccept) begin
          if (bus.DataIn == runVal) begin
            countNxt = cntInc;
            if (cntInc == MAX_CNT) begin
              pendingNxt = 1'b0;
              stateNxt   = EMIT_VAL;
            end
          end else begin
            // the breaking word is parked until the closed pair has left
            nextValNxt = bus.DataIn;
            pendingNxt = 1'b1;
            stateNxt   = EMIT_VAL;
          end
        end
      end
      EMIT_VAL: begin
        if (outXfer) stateNxt = EMIT_CNT;
      end
      EMIT_CNT: begin
        if (outXfer) begin
          if (pending) begin
            runValNxt  = nextVal;
            countNxt   = ONE;
            pendingNxt = 1'b0;
            stateNxt   = (MAX_CNT == ONE) ? EMIT_VAL : RUN;
          end else begin
            countNxt = '0;
            stateNxt = IDLE;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so the value word
  // appears the cycle after the closing edge and holds under backpressure.
  always_comb begin
    rdyNxt  = (stateNxt == IDLE) || (stateNxt == RUN);
    vldNxt  = (stateNxt == EMIT_VAL) || (stateNxt == EMIT_CNT);
    dataNxt = '0;
    case (stateNxt)
      EMIT_VAL: dataNxt = runValNxt;
      EMIT_CNT: dataNxt = countNxt;
      default:  dataNxt = '0;
    endcase
  end

endmodule

// File: tb/tb_dpcm_rle_encoder.sv
// Directed bench for dpcm_rle_encoder: hand-computed {value,count} sequences,
// backpressure, flush corner cases and asynchronous reset.
module tb_dpcm_rle_encoder;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH-1:0] outQ[$];
  logic [WIDTH-1:0] expQ[$];

  dpcm_rle_encoder_if #(.WIDTH(WIDTH)) bus ();

  dpcm_rle_encoder #(.WIDTH(WIDTH), .MAX_RUN(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so a word seen here with
  // ReadyOut high is the one transferred on the next rising edge.
  always @(negedge clk)
    if (!rst && bus.ValidOut && bus.ReadyOut) outQ.push_back(bus.DataOut);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] v);
    int  k;
    logic got;
    k   = 0;
    got = 1'b0;
    bus.ValidIn = 1'b1;
    bus.DataIn  = v;
    while (!got && k < 500) begin
      @(negedge clk);
      got = bus.ReadyIn;
      @(posedge clk);
      #1;
      k++;
    end
    bus.ValidIn = 1'b0;
    if (!got) check("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic flushPulse();
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
  endtask

  task automatic waitQ(input int n);
    int k;
    k = 0;
    while (outQ.size() < n && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag);
    waitQ(expQ.size());
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_len"}, 32'(outQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (i < outQ.size()) check($sformatf("%s_w%0d", tag, i), 32'(outQ[i]), 32'(expQ[i]));
    outQ.delete();
    expQ.delete();
  endtask

  initial begin
    bus.ValidIn  = 1'b0;
    bus.DataIn   = '0;
    bus.Flush    = 1'b0;
    bus.ReadyOut = 1'b1;

    // Reset state
    #1;
    check("rst_readyIn", 32'(bus.ReadyIn), 32'd0);
    check("rst_validOut", 32'(bus.ValidOut), 32'd0);
    check("rst_dataOut", 32'(bus.DataOut), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_readyIn", 32'(bus.ReadyIn), 32'd1);

    // 1: basic run
    sendWord(8'd5); sendWord(8'd5); sendWord(8'd5); sendWord(8'd9);
    waitQ(2);
    flushPulse();
    expQ = '{8'd5, 8'd3, 8'd9, 8'd1};
    checkOut("basic");

    // 2: saturation at 255
    for (int i = 0; i < 300; i++) sendWord(8'h00);
    waitQ(2);
    flushPulse();
    expQ = '{8'h00, 8'hFF, 8'h00, 8'h2D};
    checkOut("sat");

    // 3: backpressure on the value word
    bus.ReadyOut = 1'b0;
    sendWord(8'd7); sendWord(8'd7);
    flushPulse();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), 32'(bus.ValidOut), 32'd1);
      check($sformatf("bp_data%0d", i), 32'(bus.DataOut), 32'd7);
      check($sformatf("bp_ready%0d", i), 32'(bus.ReadyIn), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ReadyOut = 1'b1;
    expQ = '{8'd7, 8'd2};
    checkOut("bp");

    // 4: alternating values, then flush in IDLE
    sendWord(8'd1); sendWord(8'd2); sendWord(8'd1);
    waitQ(4);
    flushPulse();
    expQ = '{8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1};
    checkOut("alt");
    flushPulse();
    repeat (6) @(posedge clk);
    #1;
    check("idle_flush_len", 32'(outQ.size()), 32'd0);
    check("idle_flush_valid", 32'(bus.ValidOut), 32'd0);

    // 5: Flush and ValidIn together in RUN
    sendWord(8'd3);
    bus.ValidIn = 1'b1;
    bus.DataIn  = 8'd6;
    bus.Flush   = 1'b1;
    @(negedge clk);
    check("flush_vin_ready", 32'(bus.ReadyIn), 32'd0);
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    sendWord(8'd6);
    flushPulse();
    expQ = '{8'd3, 8'd1, 8'd6, 8'd1};
    checkOut("flush_vin");

    // 6: async reset while in EMIT_CNT
    bus.ReadyOut = 1'b0;
    sendWord(8'd4); sendWord(8'd5);
    bus.ReadyOut = 1'b1;
    @(posedge clk);
    #1;
    bus.ReadyOut = 1'b0;
    @(negedge clk);
    check("emitcnt_data", 32'(bus.DataOut), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.ValidOut), 32'd0);
    check("async_rst_ready", 32'(bus.ReadyIn), 32'd0);
    check("async_rst_data", 32'(bus.DataOut), 32'd0);
    #10;
    rst = 1'b0;
    outQ.delete();
    bus.ReadyOut = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_readyIn", 32'(bus.ReadyIn), 32'd1);
    sendWord(8'd4);
    flushPulse();
    expQ = '{8'd4, 8'd1};
    checkOut("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
